// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: deterministic AXI-Stream packet source with a sweeping packet length.
// Optional 2-cycle inter-packet gap is enabled by defining TRAFFIC_GEN_GAP_EN.
module axis_traffic_gen #(
  parameter int          DWIDTH  = 512,
  parameter int unsigned PKT_NUM = 1000,
  parameter int          MIN_LEN = 64,
  parameter int          MAX_LEN = 9600
) (
  input  logic                tx_clk,
  input  logic                rst,
  input  logic                start,
  output logic [DWIDTH-1:0]   m_axis_tdata,
  output logic [DWIDTH/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                send_done,
  output logic [31:0]         pkt_cnt
);

  localparam int          BB       = DWIDTH / 8;
  localparam logic [31:0] LAST_PKT = 32'(PKT_NUM - 1);

`ifdef TRAFFIC_GEN_GAP_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t      state, state_n;
  logic [31:0] seq, seq_n;
  logic [15:0] len, len_n;
  logic [15:0] off, off_n;
  logic [31:0] cnt_n;
  logic        done_n;
  logic        valid_n;
  logic        load;
`ifdef TRAFFIC_GEN_GAP_EN
  logic        gap_cnt, gap_n;
`endif

  logic [DWIDTH-1:0] beat_data;
  logic [BB-1:0]     beat_keep;
  logic              beat_last;

  // Next-state logic; a new beat is loaded into the output register whenever load is set.
  always_comb begin
    state_n = state;
    seq_n   = seq;
    len_n   = len;
    off_n   = off;
    cnt_n   = pkt_cnt;
    done_n  = send_done;
    valid_n = m_axis_tvalid;
    load    = 1'b0;
`ifdef TRAFFIC_GEN_GAP_EN
    gap_n   = gap_cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (PKT_NUM == 0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = SEND;
          end
        end
      end
      SEND: begin
        if (!m_axis_tvalid) begin
          load    = 1'b1;
          valid_n = 1'b1;
        end else if (m_axis_tready) begin
          if (!m_axis_tlast) begin
            off_n = off + 16'(BB);
            load  = 1'b1;
          end else begin
            seq_n = seq + 32'd1;
            cnt_n = pkt_cnt + 32'd1;
            len_n = (len == 16'(MAX_LEN)) ? 16'(MIN_LEN) : len + 16'd1;
            off_n = '0;
            if (pkt_cnt == LAST_PKT) begin
              state_n = DONE;
              done_n  = 1'b1;
              valid_n = 1'b0;
            end else begin
`ifdef TRAFFIC_GEN_GAP_EN
              state_n = GAP;
              gap_n   = 1'b0;
              valid_n = 1'b0;
`else
              load    = 1'b1;
`endif
            end
          end
        end
      end
`ifdef TRAFFIC_GEN_GAP_EN
      // Loading on the second gap cycle keeps the idle span at exactly two cycles.
      GAP: begin
        if (gap_cnt) begin
          state_n = SEND;
          load    = 1'b1;
          valid_n = 1'b1;
        end else begin
          gap_n = 1'b1;
        end
      end
`endif
      DONE: begin
        valid_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Beat built from the post-update seq/len/offset so back-to-back packets see fresh values.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int unsigned i = 0; i < BB; i++) begin
      if (({1'b0, off_n} + 17'(i)) < {1'b0, len_n}) begin
        beat_keep[i]        = 1'b1;
        beat_data[i*8 +: 8] = seq_n[7:0] + off_n[7:0] + 8'(i);
      end
    end
    beat_last = ({1'b0, off_n} + 17'(BB)) >= {1'b0, len_n};
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      seq           <= '0;
      len           <= 16'(MIN_LEN);
      off           <= '0;
      pkt_cnt       <= '0;
      send_done     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
`ifdef TRAFFIC_GEN_GAP_EN
      gap_cnt       <= 1'b0;
`endif
    end else begin
      state         <= state_n;
      seq           <= seq_n;
      len           <= len_n;
      off           <= off_n;
      pkt_cnt       <= cnt_n;
      send_done     <= done_n;
      m_axis_tvalid <= valid_n;
`ifdef TRAFFIC_GEN_GAP_EN
      gap_cnt       <= gap_n;
`endif
      if (!valid_n) begin
        m_axis_tdata <= '0;
        m_axis_tkeep <= '0;
        m_axis_tlast <= 1'b0;
      end else if (load) begin
        m_axis_tdata <= beat_data;
        m_axis_tkeep <= beat_keep;
        m_axis_tlast <= beat_last;
      end
    end
  end

endmodule

// File: doc/axis_traffic_gen.md
Name: axis_traffic_gen

Overview:
- Synthesizable AXI-Stream packet generator that drives the TX-side s_axis port of the LBUS/AXIS converter in place of the file-based traffic source.
- Emits a fixed number of deterministic packets with a sweeping length and a recomputable byte pattern, so a downstream checker can verify the RX m_axis stream without golden files.
- Runs in the bus_clk domain; reports completion via send_done.

Parameters:
- DWIDTH, 512, data width in bits; multiple of 8. Beat size BB = DWIDTH/8 bytes.
- PKT_NUM, 1000, number of packets per run (32-bit); 0 allowed.
- MIN_LEN, 64, first and minimum packet length in bytes; must be at least 1.
- MAX_LEN, 9600, maximum packet length in bytes; must be at least MIN_LEN.

Ports:
- tx_clk  input  1  bus clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run from IDLE.
- m_axis_tdata  output  DWIDTH  packet data, byte 0 in bits [7:0].
- m_axis_tkeep  output  DWIDTH/8  byte enables, LSB-contiguous.
- m_axis_tlast  output  1  last beat of packet.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tready  input  1  sink ready.
- send_done  output  1  all PKT_NUM packets accepted; sticky.
- pkt_cnt  output  32  packets fully accepted (tlast handshakes) this run.

Behaviour:
- Reset (asynchronous, immediate, including mid-packet): tvalid, tlast and send_done are 0; tdata and tkeep are 0; pkt_cnt is 0; FSM is IDLE; sequence number seq is 0; current length len is MIN_LEN.
- States:
  - IDLE: start moves to SEND; if PKT_NUM == 0, start moves directly to DONE.
  - SEND: m_axis_tvalid is held at 1 (except during a gap when the optional feature is enabled). The handshake is tvalid && tready. A tlast handshake on packet PKT_NUM-1 moves to DONE.
  - DONE: tvalid is 0; send_done is 1 until rst. start is ignored.
- start received in SEND or DONE is ignored.
- Beats per packet: ceil(len/BB). Every beat has full tkeep except the last, whose tkeep has the low (len - BB*(beats-1)) bits set. tlast is 1 only on the last beat.
- Payload: the byte at absolute packet offset k is (seq[7:0] + k[7:0]) mod 256. Bytes outside tkeep are 0.
- On a tlast handshake:
  - seq increments.
  - pkt_cnt increments.
  - len becomes len+1, or MIN_LEN if len == MAX_LEN (wrap).
- AXIS rules:
  - tdata, tkeep and tlast stay stable while tvalid && !tready.
  - tvalid never drops mid-packet without a handshake.
  - Back-to-back packets: the first beat of packet n+1 is presented in the cycle after packet n's tlast handshake.
- Latency: first beat is valid on the second clock edge after start is sampled (one cycle for the IDLE→SEND transition, one cycle for the output register).
- Outputs are registered; tready is not combinationally fed to any output.
- Counters: seq and pkt_cnt are 32 bits and wrap at 2^32. The byte offset k is a 16-bit counter, which must cover MAX_LEN.

Optional Feature:
- Macro: TRAFFIC_GEN_GAP_EN.
- Defined: after every tlast handshake, tvalid is forced to 0 for exactly 2 cycles before the next packet's first beat. No gap follows the final packet; the FSM goes straight to DONE.
- Undefined: no gaps; packets are back-to-back as described in Behaviour.

Test Plan:
- Basic run: PKT_NUM=3, MIN_LEN=64, MAX_LEN=130, tready tied to 1, start pulse ->
  - packet 0: 1 beat, tkeep all 1, tlast 1, byte0=0x00, byte63=0x3F.
  - packet 1: 2 beats; second beat tkeep=64'h1, byte = 0x41.
  - packet 2: 2 beats; second beat tkeep=64'h3.
  - send_done rises the cycle after the third tlast; pkt_cnt=3.
- Length wrap: PKT_NUM=3, MIN_LEN=128, MAX_LEN=129 -> lengths 128, 129, 128; packet-1 last beat tkeep=64'h1; packet-2 first byte 0x02.
- Backpressure: tready toggling 1,0,0,1 repeatedly -> tdata, tkeep and tlast are unchanged across every stalled cycle; the total accepted byte count equals the sum of lengths.
- Reset mid-packet: assert rst during beat 1 of a 3-beat packet -> tvalid goes to 0 immediately. After release plus start, the run restarts with seq=0, len=MIN_LEN, pkt_cnt=0.
- Edge cases:
  - PKT_NUM=0 with start -> send_done=1 with no tvalid ever asserted.
  - start pulsed during SEND -> no effect on the running sequence.
- Gap feature (TRAFFIC_GEN_GAP_EN defined), PKT_NUM=2, 1-beat packets -> exactly 2 tvalid=0 cycles between the packets and none after the last.
